until_monitor: RTL
==================

# until_monitor

Synthesisable multi-channel runtime checker for the "hold until release" property, in weak (`until`) and strong (`s_until`) flavours selectable per channel. Each channel arms on a start pulse, then checks every clock that its hold signal stays high until its release signal arrives. Pending obligations resolve at end-of-test or on an optional timeout. The block sits beside the DUT in simulation or emulation benches and reports pass/fail pulses, failure causes and saturating totals.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- STRONG_MASK, '0, NUM_CH-bit mask; bit i = 1 gives channel i s_until semantics, 0 gives until semantics
- MAX_WAIT, 0, bound in evaluated cycles for strong channels; 0 = unbounded
- CNT_W, 16, width of the pass/fail total counters
- clk  in  1  sampling clock; all evaluation on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  NUM_CH  per-channel attempt trigger
- hold  in  NUM_CH  per-channel left operand (must stay high)
- release  in  NUM_CH  per-channel right operand (ends obligation)
- eot  in  1  end-of-test; resolves all pending obligations
- clr  in  1  synchronous clear of totals and sticky_fail
- busy  out  NUM_CH  channel has an open obligation
- pass  out  NUM_CH  one-cycle pass pulse
- fail  out  NUM_CH  one-cycle fail pulse
- fail_code  out  2*NUM_CH  cause of the last failure per channel, held until the next failure or clr
- sticky_fail  out  NUM_CH  set on any failure, cleared by clr
- pass_total, fail_total  out  CNT_W each  saturating totals over all channels

## Operation
- Per-channel FSM: IDLE, ARMED. Every output resets to 0 and fail_code resets to NONE.
- Evaluation cycle: the start edge in IDLE, or any edge in ARMED. Priority within one evaluation:
  1. release=1 -> pass. hold is not checked in the release cycle.
  2. hold=0 -> fail, code HOLD_DROP.
  3. eot=1 -> strong channel: fail, code EOT_PENDING. Weak channel: pass.
  4. Strong channel with MAX_WAIT>0 and wait_cnt == MAX_WAIT-1 -> fail, code TIMEOUT.
  5. Otherwise go to or stay in ARMED and increment wait_cnt.
- Resolution returns the channel to IDLE and clears wait_cnt.
- start while ARMED is ignored; there is one outstanding attempt per channel.
- start on the resolving edge does not re-arm; a new attempt needs a start in IDLE.
- Weak channels never time out. Under the weak rule, permanent hold=1 and release=0 never fails.
- eot with start in IDLE: evaluate as one start cycle with eot applied, using rules 1-3.
- Totals each add popcount(pass) or popcount(fail) per cycle. They saturate at 2^CNT_W-1 and do not wrap.
- clr zeroes the totals, sticky_fail and fail_code. It does not affect FSMs. Increments in the clr cycle are discarded.
- Reset mid-obligation: all channels go to IDLE immediately with no pass/fail reported.

## Timing
- hold/release/start/eot are sampled at posedge k. pass/fail/fail_code/busy update at the same edge k (registered decision), so a pulse is high for exactly cycle k..k+1.
- busy rises at the start edge only if unresolved, and falls at the resolving edge.
- Totals update one edge after the pulse edge (k+1).
- Minimum attempt length is 1 evaluated cycle. The maximum for strong channels is MAX_WAIT cycles.

## Structure
- until_mon_pkg: the fail_code_t enum (NONE=0, HOLD_DROP=1, EOT_PENDING=2, TIMEOUT=3), the state_t enum, and a popcount function.
- Sub-module until_mon_ch: one FSM plus a wait counter of width $clog2(MAX_WAIT+1), with STRONG and MAX_WAIT as parameters. It is instantiated NUM_CH times in a generate loop.
- The top level holds the totals, sticky logic and clr.

## Test plan
- Weak ch0: start at cycle 1, hold=1, release=0 for 20 cycles, then eot -> pass[0] at the eot edge, fail_total=0.
- Strong ch1 with the same stimulus -> fail[1] at the eot edge, fail_code=EOT_PENDING, sticky_fail[1]=1.
- Strong ch2 with MAX_WAIT=8: start, hold=1, no release -> fail[2] on evaluated cycle 8, code TIMEOUT, busy[2] low after it.
- Ch3: start, hold=1 for 3 cycles, hold=0 and release=1 on cycle 4 -> pass[3] (release wins), no fail.
- Ch0: hold drops on cycle 5 with no release -> fail[0], code HOLD_DROP. A start during ARMED is ignored (single pass/fail).
- CNT_W=2: run 5 passes -> pass_total saturates at 3. clr -> 0. Then assert rst_n low mid-attempt -> busy=0 and no pulse.

Source files
------------

// File: rtl/until_mon_pkg.sv
// -----------------------------------------------------------------------------
// until_mon_pkg
// Shared types for the "hold until release" runtime checker.
//   fail_code_t : failure cause reported per channel
//   state_t     : per-channel obligation state
//   popcount    : number of set bits in a 32-bit vector (0..32)
// -----------------------------------------------------------------------------
package until_mon_pkg;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    HOLD_DROP   = 2'd1,
    EOT_PENDING = 2'd2,
    TIMEOUT     = 2'd3
  } fail_code_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/until_mon_ch.sv
// -----------------------------------------------------------------------------
// until_mon_ch
// One checker channel: IDLE/ARMED FSM plus a wait counter. Decisions are
// computed combinationally from the sampled inputs and registered, so a
// pass/fail pulse appears at the same edge that samples the deciding inputs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : attempt trigger (honoured only in IDLE)
//   hold       : left operand, must stay high while armed
//   rel        : release operand, ends the obligation with a pass
//   eot        : end-of-test, resolves a pending obligation
//   busy       : obligation open
//   pass, fail : registered one-cycle result pulses
//   fail_now   : unregistered fail decision for this edge
//   code_now   : unregistered failure cause for this edge
// -----------------------------------------------------------------------------
module until_mon_ch
  import until_mon_pkg::*;
#(
  parameter bit          STRONG   = 1'b0,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hold,
  input  logic       rel,
  input  logic       eot,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       fail_now,
  output fail_code_t code_now
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  // Only strong channels with a nonzero bound can time out.
  localparam bit TIMED = STRONG && (MAX_WAIT > 0);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, cnt_nxt;
  logic              eval;
  logic              pass_now;

  // An edge is evaluated when armed, or when a start arrives in IDLE.
  assign eval = (state == ARMED) || start;
  assign busy = (state == ARMED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      pass     <= pass_now;
      fail     <= fail_now;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    if (eval) begin
      if (pass_now || fail_now) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ARMED;
        cnt_nxt   = wait_cnt + 1'b1;
      end
    end
  end

  // Decision priority: release, hold drop, end-of-test, timeout.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pass_now = 1'b0;
    fail_now = 1'b0;
    code_now = NONE;
    if (eval) begin
      if (rel) begin
        pass_now = 1'b1;
      end else if (!hold) begin
        fail_now = 1'b1;
        code_now = HOLD_DROP;
      end else if (eot) begin
        if (STRONG) begin
          fail_now = 1'b1;
          code_now = EOT_PENDING;
        end else begin
          pass_now = 1'b1;
        end
      end else if (TIMED && (wait_cnt == LAST_CNT)) begin
        fail_now = 1'b1;
        code_now = TIMEOUT;
      end
    end
  end

endmodule

// File: rtl/until_monitor.sv
// -----------------------------------------------------------------------------
// until_monitor
// Multi-channel "hold until release" checker, weak or strong per channel.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : per-channel attempt trigger
//   hold        : per-channel left operand (must stay high)
//   rel         : per-channel release operand (ends the obligation)
//   eot         : end-of-test, resolves all pending obligations
//   clr         : synchronous clear of totals, sticky_fail and fail_code
//   busy        : per-channel open obligation
//   pass, fail  : per-channel one-cycle result pulses
//   fail_code   : 2 bits per channel, cause of the last failure
//   sticky_fail : per-channel failure seen since reset/clr
//   pass_total, fail_total : saturating totals over all channels
// -----------------------------------------------------------------------------
module until_monitor
  import until_mon_pkg::*;
#(
  parameter int unsigned        NUM_CH      = 4,
  parameter logic [NUM_CH-1:0]  STRONG_MASK = '0,
  parameter int unsigned        MAX_WAIT    = 0,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   start,
  input  logic [NUM_CH-1:0]   hold,
  input  logic [NUM_CH-1:0]   rel,
  input  logic                eot,
  input  logic                clr,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   pass,
  output logic [NUM_CH-1:0]   fail,
  output logic [2*NUM_CH-1:0] fail_code,
  output logic [NUM_CH-1:0]   sticky_fail,
  output logic [CNT_W-1:0]    pass_total,
  output logic [CNT_W-1:0]    fail_total
);

  localparam int unsigned       SUM_W   = CNT_W + 6;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [NUM_CH-1:0] fail_now;
  fail_code_t        code_now [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    until_mon_ch #(
      .STRONG   (STRONG_MASK[i]),
      .MAX_WAIT (MAX_WAIT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[i]),
      .hold     (hold[i]),
      .rel      (rel[i]),
      .eot      (eot),
      .busy     (busy[i]),
      .pass     (pass[i]),
      .fail     (fail[i]),
      .fail_now (fail_now[i]),
      .code_now (code_now[i])
    );
  end

  // Cause and sticky flags update on the deciding edge, alongside fail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_code   <= '0;
      sticky_fail <= '0;
    end else if (clr) begin
      fail_code   <= '0;
      sticky_fail <= '0;
    end else begin
      sticky_fail <= sticky_fail | fail_now;
      for (int i = 0; i < NUM_CH; i++) begin
        if (fail_now[i]) fail_code[2*i +: 2] <= code_now[i];
      end
    end
  end

  // Totals accumulate the registered pulses, one edge after they appear.
  logic [SUM_W-1:0] pass_sum, fail_sum;
  logic [CNT_W-1:0] pass_sat, fail_sat;

  assign pass_sum = SUM_W'(pass_total) + SUM_W'(popcount(32'(pass)));
  assign fail_sum = SUM_W'(fail_total) + SUM_W'(popcount(32'(fail)));
  assign pass_sat = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
  assign fail_sat = (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_total <= '0;
      fail_total <= '0;
    end else if (clr) begin
      pass_total <= '0;
      fail_total <= '0;
    end else begin
      pass_total <= pass_sat;
      fail_total <= fail_sat;
    end
  end

endmodule
